// File: rtl/phibin_pt_histogram.sv
// Per-event phi-bin pT histogram.
// Accumulates saturating track pT sums per phi bin. On the event's last track it
// streams every bin sum out in bin order, clearing each bin as it is emitted.
module phibin_pt_histogram #(
   parameter int unsigned NBINS = 27,
   parameter int unsigned PT_W  = 16,
   parameter int unsigned SUM_W = 20,
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_phi_bin,
   input  logic [PT_W-1:0]  in_pt,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_bin,
   output logic [SUM_W-1:0] out_sum,
   output logic             out_last,
   output logic [ERR_W-1:0] err_drop
);

   localparam int unsigned BIN_W = 5;
   localparam int unsigned ACC_W = SUM_W + 1;
   localparam int unsigned CMP_W = BIN_W + 1;
   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NBINS - 1);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DRAIN = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [BIN_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [SUM_W-1:0] sum_q [NBINS];
   logic [SUM_W-1:0] sum_d [NBINS];
   logic [ERR_W-1:0] err_q, err_d;

   logic bin_ok_c;
   logic accept_c;
   logic emit_c;
   logic at_last_bin_c;

   // Add a zero-extended pT to a bin sum; the carry-out clamps to all ones.
   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [PT_W-1:0]  b);
      logic [ACC_W-1:0] t;
      t = ACC_W'(a) + ACC_W'(b);
      return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
   endfunction

   // Handshake qualifiers; the bin check is one bit wider so NBINS=32 still works.
   always_comb begin
      bin_ok_c      = ({1'b0, in_phi_bin} < CMP_W'(NBINS));
      accept_c      = in_valid && in_ready;
      emit_c        = out_valid && out_ready;
      at_last_bin_c = (rd_ptr_q == LAST_BIN);
   end

   // Next-state, bin update and output decode.
   always_comb begin
      state_d   = state_q;
      rd_ptr_d  = rd_ptr_q;
      sum_d     = sum_q;
      err_d     = err_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_bin   = '0;
      out_sum   = '0;
      out_last  = 1'b0;

      unique case (state_q)
         ST_ACCUM: begin
            in_ready = 1'b1;
            if (accept_c) begin
               if (bin_ok_c) begin
                  for (int i = 0; i < int'(NBINS); i++) begin
                     if (BIN_W'(i) == in_phi_bin) begin
                        sum_d[i] = sat_add(sum_q[i], in_pt);
                     end
                  end
               end else if (err_q != {ERR_W{1'b1}}) begin
                  err_d = err_q + ERR_W'(1);
               end
               if (in_last) begin
                  state_d  = ST_DRAIN;
                  rd_ptr_d = '0;
               end
            end
         end

         ST_DRAIN: begin
            out_valid = 1'b1;
            out_bin   = rd_ptr_q;
            out_sum   = sum_q[rd_ptr_q];
            out_last  = at_last_bin_c;
            if (emit_c) begin
               sum_d[rd_ptr_q] = '0;
               if (at_last_bin_c) begin
                  rd_ptr_d = '0;
                  state_d  = ST_ACCUM;
               end else begin
                  rd_ptr_d = rd_ptr_q + BIN_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   // State, read pointer and drop counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_ACCUM;
         rd_ptr_q <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
      end
   end

   // Bin accumulator registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(NBINS); i++) begin
            sum_q[i] <= '0;
         end
      end else begin
         sum_q <= sum_d;
      end
   end

   assign err_drop = err_q;

endmodule

// File: tb/tb_phibin_pt_histogram.sv
// Directed self-checking bench for phibin_pt_histogram.
module tb_phibin_pt_histogram;

   localparam int unsigned NBINS = 27;
   localparam int unsigned PT_W  = 16;
   localparam int unsigned SUM_W = 20;
   localparam int unsigned ERR_W = 8;
   localparam int unsigned VEC_W = 1 + 5 + SUM_W + 1 + 1;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_phi_bin;
   logic [PT_W-1:0]  in_pt;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       out_bin;
   logic [SUM_W-1:0] out_sum;
   logic             out_last;
   logic [ERR_W-1:0] err_drop;

   int errors;
   int checks;
   logic [SUM_W-1:0] exp_sum [NBINS];

   phibin_pt_histogram #(
      .NBINS(NBINS), .PT_W(PT_W), .SUM_W(SUM_W), .ERR_W(ERR_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_phi_bin(in_phi_bin),
      .in_pt(in_pt), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
      .out_sum(out_sum), .out_last(out_last), .err_drop(err_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_exp();
      for (int i = 0; i < int'(NBINS); i++) exp_sum[i] = '0;
   endtask

   // Present one track at a negedge and let the next posedge take it.
   task automatic send(input int bin, input int pt, input logic last);
      in_valid   = 1'b1;
      in_phi_bin = 5'(bin);
      in_pt      = PT_W'(pt);
      in_last    = last;
      @(negedge clk);
      in_valid   = 1'b0;
      in_last    = 1'b0;
   endtask

   // Full-speed drain against exp_sum, then confirm return to accumulate.
   task automatic drain_full(input string tag);
      logic [VEC_W-1:0] obs, exp;
      for (int b = 0; b < int'(NBINS); b++) begin
         obs = {out_valid, out_bin, out_sum, out_last, in_ready};
         exp = {1'b1, 5'(b), exp_sum[b], (b == int'(NBINS) - 1), 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s bin%0d: got v=%b bin=%0d sum=%h last=%b rdy=%b, want v=1 bin=%0d sum=%h last=%b rdy=0",
                     tag, b, out_valid, out_bin, out_sum, out_last, in_ready,
                     b, exp_sum[b], (b == int'(NBINS) - 1));
         end
         out_ready = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL %s end: got out_valid=%b in_ready=%b, want 0 1", tag, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; in_phi_bin = '0; in_pt = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, in_ready, err_drop, out_bin, out_sum, out_last} !== {1'b0, 1'b1, 8'd0, 5'd0, 20'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset: got v=%b rdy=%b err=%0d bin=%0d sum=%h last=%b, want 0 1 0 0 0 0",
                  out_valid, in_ready, err_drop, out_bin, out_sum, out_last);
      end
      reset = 1'b1;
      @(negedge clk);
      clear_exp();
      send(0, 0, 1'b1);
      drain_full("reset_drain");
   endtask

   task automatic test_basic();
      clear_exp();
      exp_sum[3]  = 20'd150;
      exp_sum[26] = 20'd7;
      send(3, 100, 1'b0);
      send(3, 50, 1'b0);
      send(26, 7, 1'b1);
      drain_full("basic");
   endtask

   task automatic test_saturation();
      clear_exp();
      exp_sum[5] = 20'hFFFFF;
      for (int i = 0; i < 20; i++) send(5, 16'hFFFF, (i == 19));
      drain_full("saturation");
   endtask

   task automatic test_bad_bin();
      clear_exp();
      send(30, 9, 1'b0);
      send(31, 1, 1'b1);
      checks++;
      if (err_drop !== 8'd2) begin
         errors++;
         $display("FAIL bad_bin err_drop: got %0d, want 2", err_drop);
      end
      drain_full("bad_bin");
   endtask

   task automatic test_err_saturation();
      clear_exp();
      for (int i = 0; i < 260; i++) send(31, 1, (i == 259));
      checks++;
      if (err_drop !== 8'd255) begin
         errors++;
         $display("FAIL err_sat: got %0d, want 255", err_drop);
      end
      drain_full("err_sat");
   endtask

   task automatic test_backpressure();
      logic [VEC_W-1:0] obs, exp;
      logic emitted;
      int b;
      int k;
      clear_exp();
      exp_sum[0]  = 20'd11;
      exp_sum[13] = 20'd22;
      exp_sum[26] = 20'd33;
      send(0, 11, 1'b0);
      send(13, 22, 1'b0);
      send(26, 33, 1'b1);
      b = 0;
      k = 0;
      while (b < int'(NBINS) && k < 200) begin
         obs = {out_valid, out_bin, out_sum, out_last, in_ready};
         exp = {1'b1, 5'(b), exp_sum[b], (b == int'(NBINS) - 1), 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL backpressure cyc%0d bin%0d: got v=%b bin=%0d sum=%h last=%b rdy=%b, want v=1 bin=%0d sum=%h rdy=0",
                     k, b, out_valid, out_bin, out_sum, out_last, in_ready, b, exp_sum[b]);
         end
         emitted   = ((k % 3) == 0);
         out_ready = emitted;
         @(negedge clk);
         if (emitted) b++;
         k++;
      end
      out_ready = 1'b0;
      checks++;
      if ({out_valid, in_ready} !== 2'b01 || b != int'(NBINS)) begin
         errors++;
         $display("FAIL backpressure end: got out_valid=%b in_ready=%b bins=%0d, want 0 1 %0d",
                  out_valid, in_ready, b, NBINS);
      end
      // Bins emitted above must have been cleared.
      clear_exp();
      send(1, 1, 1'b1);
      exp_sum[1] = 20'd1;
      drain_full("backpressure_cleared");
   endtask

   task automatic test_reset_mid_drain();
      clear_exp();
      send(10, 5, 1'b0);
      send(2, 40, 1'b1);
      for (int b = 0; b < 10; b++) begin
         out_ready = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      checks++;
      if ({out_valid, out_bin, out_sum} !== {1'b1, 5'd10, 20'd5}) begin
         errors++;
         $display("FAIL mid_drain pre: got v=%b bin=%0d sum=%h, want 1 10 5", out_valid, out_bin, out_sum);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, err_drop} !== {1'b0, 1'b1, 8'd0}) begin
         errors++;
         $display("FAIL mid_drain reset: got v=%b rdy=%b err=%0d, want 0 1 0", out_valid, in_ready, err_drop);
      end
      reset = 1'b1;
      @(negedge clk);
      exp_sum[2]  = 20'd3;
      exp_sum[20] = 20'd4;
      send(2, 3, 1'b0);
      send(20, 4, 1'b1);
      drain_full("after_reset");
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_basic();
      test_saturation();
      test_bad_bin();
      test_err_saturation();
      test_backpressure();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
